irrigation_scheduler: RTL and testbench
=======================================

# irrigation_scheduler

Sequential controller for the greenhouse irrigation plant: debounces the six raw sensor lines (tank level H/M/L, air humidity Ua, soil humidity Us, temperature T), fills the tank and schedules sprinkler or drip irrigation runs. Each run has a bounded duration and is followed by a mandatory rest interval. Faults and alarms latch until cleared by the sensors. The block sits between the sensor pins and the valve/pump drivers and owns the Ve, Bs, Vs, Al and E lines.

## Interface
- DEBOUNCE_TICKS, 4: consecutive equal ticks before a sensor value is accepted.
- MAX_RUN_TICKS, 60: maximum irrigation run length, in ticks.
- REST_TICKS, 10: minimum idle time after any run or fault, in ticks.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-clk enable pulse, nominally 1 Hz; all timers and debouncers advance only on tick.
- H, M, L  in  1 each  tank level probes (high, medium, low); 1 = wet.
- Ua  in  1  air humidity high.
- Us  in  1  soil humidity high (soil wet).
- T  in  1  temperature high.
- Ve  out  1  tank inlet valve open.
- Bs  out  1  sprinkler pump on.
- Vs  out  1  drip valve open.
- Al  out  1  alarm.
- E  out  1  sensor-consistency error.

## Operation
- Debounce: each sensor has a debouncer with reset value 0. The debounced value (dH, dM, dL, dUa, dUs, dT) changes only after the raw input differs from it for DEBOUNCE_TICKS consecutive ticks. Any tick with the raw input equal to the debounced value restarts the count.
- Inconsistency: inc = (dM & ~dL) | (dH & ~dM).
- States: IDLE, SPRINKLE, DRIP, REST, FAULT.
- IDLE:
  - inc -> FAULT.
  - Otherwise, if ~dUs & dL: go to DRIP when dT & ~dUa (hot, dry air), else go to SPRINKLE.
- SPRINKLE/DRIP: exit on the first applicable condition, priority inc > ~dL > dUs > run counter == MAX_RUN_TICKS-1 on a tick.
  - inc -> FAULT.
  - All other exits -> REST.
  - Climate changes during a run do not switch the run mode.
- REST: count REST_TICKS ticks, then go to IDLE. inc -> FAULT at any time.
- FAULT: stay while inc is true. When inc clears, go to REST with the rest counter cleared.
- Run and rest counters clear on every state entry. Width is $clog2(max(MAX_RUN_TICKS, REST_TICKS)+1).
- Outputs, registered from next-state and next debounced values:
  - Bs = (state == SPRINKLE).
  - Vs = (state == DRIP).
  - E = (state == FAULT).
  - Al = E | ~dL.
  - Ve = ~dH & ~E. The tank fills independently of irrigation.
- Bs and Vs are never 1 together.

## Timing
- Reset: on the rst edge, all outputs are 0, state is IDLE, and all counters and debounced values are 0.
  - First cycle after reset: Al=1 and Ve=1 (debounced tank reads empty) until the probes are accepted.
- Reset mid-run: Bs/Vs drop at the rst edge, with no REST afterwards.
- Sensor edge to output: DEBOUNCE_TICKS ticks, plus 1 clk for the output register.
- Run length: at most MAX_RUN_TICKS ticks. Bs/Vs rise 1 clk after IDLE decides and fall 1 clk after the exit condition.
- tick held high for multiple clks counts once per clk. tick arriving in the same clk as a state transition is consumed by the new state's counter start (counter stays 0).
- Simultaneous events in one clk: priority rst > inc > ~dL > dUs > timeout.
- A raw input change with tick low has no effect until the next tick.

## Structure
- Package irrigation_pkg:
  - state enum irr_state_t (IDLE, SPRINKLE, DRIP, REST, FAULT).
  - Default parameter constants.
  - Function is_inconsistent(h, m, l).
- Sub-module sensor_debouncer (parameter DEBOUNCE_TICKS; ports clk, rst, tick, raw, stable), instantiated six times.
- The top holds the FSM, the counters and the output registers.

## Test plan
Bench parameters: DEBOUNCE_TICKS=2, MAX_RUN_TICKS=5, REST_TICKS=3, tick every 4 clks.
- Reset, then H=M=L=1, Us=0, Ua=1, T=0 -> after 2 ticks Al=0, Ve=0; Bs=1 for exactly 5 ticks, Vs=0; then 3 ticks of rest; then Bs=1 again.
- Same setup with Ua=0, T=1 -> Vs=1, Bs=0. Toggle T to 0 mid-run -> Vs stays 1 until timeout.
- During a run, drive L=M=H=0 -> 2 ticks later Al=1, Bs=0, Ve=1, state REST.
- Drive M=1, L=0 -> E=1, Al=1, Ve=0, Bs=Vs=0. Restore L=1 -> E=0 after 2 ticks; no run before 3 rest ticks.
- Raw Us glitches to 1 for 1 tick during a run -> no exit; Us=1 for 2 ticks -> Bs=0.
- Assert rst mid-run and on the same clk as tick -> all outputs 0 next edge; counters restart from 0 after release.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the greenhouse irrigation scheduler.
package irrigation_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPRINKLE,
      DRIP,
      REST,
      FAULT
   } irr_state_t;

   localparam int DEF_DEBOUNCE_TICKS = 4;
   localparam int DEF_MAX_RUN_TICKS  = 60;
   localparam int DEF_REST_TICKS     = 10;

   // A wetter probe above a dry one means a stuck or broken level sensor.
   function automatic logic is_inconsistent(input logic h, input logic m, input logic l);
      return (m & ~l) | (h & ~m);
   endfunction

endpackage

// File: rtl/irrigation_scheduler_debouncer.sv
// Tick-based debouncer: the output follows the raw line only after it has
// disagreed with the accepted value for DEBOUNCE_TICKS consecutive ticks.
module sensor_debouncer
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic stable
);

   localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (tick) begin
         if (raw == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_d = raw;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Greenhouse irrigation controller: debounced sensors drive a run/rest FSM
// and registered valve, pump, alarm and error outputs.
//
// state    | meaning
// IDLE     | waiting for dry soil with water in the tank
// SPRINKLE | sprinkler pump running, run timer active
// DRIP     | drip valve open, run timer active
// REST     | mandatory pause after a run or fault, rest timer active
// FAULT    | level probes inconsistent, irrigation blocked
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int MAX_RUN_TICKS  = DEF_MAX_RUN_TICKS,
   parameter int REST_TICKS     = DEF_REST_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic H,
   input  logic M,
   input  logic L,
   input  logic Ua,
   input  logic Us,
   input  logic T,
   output logic Ve,
   output logic Bs,
   output logic Vs,
   output logic Al,
   output logic E
);

   localparam int CNT_MAX = (MAX_RUN_TICKS > REST_TICKS) ? MAX_RUN_TICKS : REST_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_TICKS - 1);
   localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(REST_TICKS - 1);

   logic [5:0] raw_vec;
   logic [5:0] stb_vec;
   logic       d_h, d_m, d_l, d_ua, d_us, d_t;

   assign raw_vec = {H, M, L, Ua, Us, T};
   assign {d_h, d_m, d_l, d_ua, d_us, d_t} = stb_vec;

   for (genvar g = 0; g < 6; g++) begin : g_deb
      sensor_debouncer #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .raw    (raw_vec[g]),
         .stable (stb_vec[g])
      );
   end

   irr_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc;
   logic             ve_q, bs_q, vs_q, al_q, e_q;
   logic             ve_d, bs_d, vs_d, al_d, e_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc     = is_inconsistent(d_h, d_m, d_l);

      if (tick && (state_q == SPRINKLE || state_q == DRIP || state_q == REST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (inc) begin
               state_d = FAULT;
            end else if (~d_us & d_l) begin
               state_d = (d_t & ~d_ua) ? DRIP : SPRINKLE;
            end
         end
         SPRINKLE, DRIP: begin
            if (inc) begin
               state_d = FAULT;
            end else if (~d_l || d_us || (tick && cnt_q == RUN_LAST)) begin
               state_d = REST;
            end
         end
         REST: begin
            if (inc) begin
               state_d = FAULT;
            end else if (tick && cnt_q == REST_LAST) begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (!inc) begin
               state_d = REST;
            end
         end
         default: state_d = IDLE;
      endcase

      // Entering a state swallows any tick seen on the same clock.
      if (state_d != state_q) begin
         cnt_d = '0;
      end

      e_d  = (state_d == FAULT);
      bs_d = (state_d == SPRINKLE);
      vs_d = (state_d == DRIP);
      al_d = e_d | ~d_l;
      ve_d = ~d_h & ~e_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ve_q    <= 1'b0;
         bs_q    <= 1'b0;
         vs_q    <= 1'b0;
         al_q    <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ve_q    <= ve_d;
         bs_q    <= bs_d;
         vs_q    <= vs_d;
         al_q    <= al_d;
         e_q     <= e_d;
      end
   end

   assign Ve = ve_q;
   assign Bs = bs_q;
   assign Vs = vs_q;
   assign Al = al_q;
   assign E  = e_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with short timers and a tick every 4 clocks.
module tb_irrigation_scheduler;

   logic clk = 1'b0;
   logic rst, tick;
   logic H, M, L, Ua, Us, T;
   logic Ve, Bs, Vs, Al, E;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [5:0] raw;   // {H,M,L,Ua,Us,T}
      logic [4:0] exp;   // {Ve,Bs,Vs,Al,E}
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   irrigation_scheduler #(
      .DEBOUNCE_TICKS(2),
      .MAX_RUN_TICKS (5),
      .REST_TICKS    (3)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .H    (H),
      .M    (M),
      .L    (L),
      .Ua   (Ua),
      .Us   (Us),
      .T    (T),
      .Ve   (Ve),
      .Bs   (Bs),
      .Vs   (Vs),
      .Al   (Al),
      .E    (E)
   );

   task automatic chk(input string name, input logic [4:0] exp);
      logic [4:0] got;
      got = {Ve, Bs, Vs, Al, E};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got {Ve,Bs,Vs,Al,E}=%b expected=%b", name, got, exp);
      end
   endtask

   task automatic add(input logic [5:0] r, input logic [4:0] e, input int n);
      vec_t v;
      v.raw = r;
      v.exp = e;
      repeat (n) tbl.push_back(v);
   endtask

   // Called at a negedge: one tick clock followed by three quiet clocks.
   task automatic tick_period();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_table(input string prefix);
      for (int i = 0; i < tbl.size(); i++) begin
         {H, M, L, Ua, Us, T} = tbl[i].raw;
         tick_period();
         chk($sformatf("%s%0d", prefix, i + 1), tbl[i].exp);
      end
      tbl.delete();
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      {H, M, L, Ua, Us, T} = 6'b000000;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 5'b00000);
      rst = 1'b0;
      @(negedge clk);
      chk("first_cycle_after_reset", 5'b10010);

      // sprinkle run, rest, climate change mid-run, drip run, tank drop,
      // fault and recovery, soil-humidity glitch then real exit
      add(6'b111100, 5'b10010, 1);
      add(6'b111100, 5'b01000, 5);
      add(6'b111100, 5'b00000, 3);
      add(6'b111100, 5'b01000, 1);
      add(6'b111001, 5'b01000, 4);
      add(6'b111001, 5'b00000, 3);
      add(6'b111001, 5'b00100, 1);
      add(6'b111000, 5'b00100, 4);
      add(6'b111000, 5'b00000, 3);
      add(6'b111000, 5'b01000, 1);
      add(6'b000000, 5'b01000, 1);
      add(6'b000000, 5'b10010, 1);
      add(6'b010000, 5'b10010, 1);
      add(6'b010000, 5'b00011, 1);
      add(6'b011000, 5'b00011, 1);
      add(6'b011000, 5'b10000, 3);
      add(6'b011000, 5'b11000, 1);
      add(6'b011010, 5'b11000, 1);
      add(6'b011000, 5'b11000, 1);
      add(6'b011010, 5'b11000, 1);
      add(6'b011010, 5'b10000, 2);
      add(6'b011000, 5'b10000, 1);
      add(6'b011000, 5'b11000, 1);
      run_table("vec");

      // reset during a sprinkle run, coincident with a tick
      rst = 1'b1;
      tick = 1'b1;
      @(negedge clk);
      chk("rst_mid_run", 5'b00000);
      rst = 1'b0;
      tick = 1'b0;
      @(negedge clk);
      chk("rst_release", 5'b10010);

      // debouncers and run counter restart from zero, no rest after reset
      add(6'b011000, 5'b10010, 1);
      add(6'b011000, 5'b11000, 5);
      add(6'b011000, 5'b10000, 1);
      run_table("post_rst");

      // tick held high counts once per clock during rest
      tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("tick_hold_rest", 5'b10000);
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("tick_hold_run", 5'b11000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
